// File: rtl/cluster_hub_buf.sv
// ---------------------------------------------------------------------------
// cluster_hub_buf
//
// Buffered hub demultiplexer between a crossbar output and the child routers
// of one cluster. Each incoming flit is steered by its destination field into
// a per-child FIFO. Each child drains its FIFO against its own credit counter,
// so a stalled child only backpressures flits addressed to it.
//
// Optional feature macro: HUB_BCAST_EN
//   When defined, a flit with sd_in[BCAST_BIT] set is pushed into every
//   child FIFO in the same cycle. It is accepted only when no FIFO is full.
//   When undefined, BCAST_BIT is ordinary payload and no broadcast logic is
//   built.
//
// Parameters:
//   FLIT_W     flit width
//   NUM_OUT    number of children (power of two, 2..16)
//   DEST_LSB   LSB of the destination field (width $clog2(NUM_OUT))
//   FIFO_DEPTH per-child FIFO depth (power of two, >= 2)
//   CRED_INIT  credits per child after reset (child input buffer depth)
//   BCAST_BIT  broadcast flag bit (HUB_BCAST_EN builds only)
//
// Ports:
//   clk         clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   sd_in       incoming flit
//   sd_in_valid sd_in carries a flit
//   sd_in_ready hub accepts the flit this cycle (combinational)
//   cred_ret    one-cycle credit return pulse per child
//   out_flit    registered flit to child i on [i*FLIT_W +: FLIT_W]
//   out_valid   registered one-cycle delivery pulse per child
//   fifo_full   per-child FIFO full flag
//   cred_err    sticky credit-overflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module cluster_hub_buf #(
  parameter int FLIT_W     = 20,
  parameter int NUM_OUT    = 4,
  parameter int DEST_LSB   = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CRED_INIT  = 4,
  parameter int BCAST_BIT  = FLIT_W - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_W-1:0]           sd_in,
  input  logic                        sd_in_valid,
  output logic                        sd_in_ready,
  input  logic [NUM_OUT-1:0]          cred_ret,
  output logic [NUM_OUT*FLIT_W-1:0]   out_flit,
  output logic [NUM_OUT-1:0]          out_valid,
  output logic [NUM_OUT-1:0]          fifo_full,
  output logic                        cred_err
);

  localparam int DW = $clog2(NUM_OUT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CRED_INIT + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CRED_INIT);

  logic [DW-1:0]      dest;
  logic               xfer;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic [NUM_OUT-1:0] cred_ovf;

  assign dest = sd_in[DEST_LSB +: DW];

  // Ready looks only at the pre-edge full flags, so a pop in the same cycle
  // never frees room for a push into a full FIFO. Ready is forced low while
  // reset is asserted so nothing is accepted in a reset cycle.
`ifdef HUB_BCAST_EN
  logic bcast;
  assign bcast       = sd_in[BCAST_BIT];
  assign sd_in_ready = !rst && (bcast ? !(|fifo_full) : !fifo_full[dest]);
`else
  assign sd_in_ready = !rst && !fifo_full[dest];
`endif

  assign xfer = sd_in_valid && sd_in_ready;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     credit;
    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [FLIT_W-1:0] flit_q;
    logic              valid_q;

`ifdef HUB_BCAST_EN
    assign push[i] = xfer && (bcast || (dest == DW'(i)));
`else
    assign push[i] = xfer && (dest == DW'(i));
`endif

    // The extra pointer MSB distinguishes full (same index, different lap)
    // from empty (pointers identical).
    assign fifo_full[i] = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                          (wr_ptr[AW] != rd_ptr[AW]);

    // A child is served whenever it has something queued and credit left;
    // the credit test alone keeps the counter from going below zero.
    assign pop[i] = (wr_ptr != rd_ptr) && (credit != '0);

    // A return at full credit with no send in the same cycle has nowhere to
    // go; it is dropped and reported through cred_err.
    assign cred_ovf[i] = cred_ret[i] && !pop[i] && (credit == CRED_MAX);

    // FIFO storage has no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem[wr_ptr[AW-1:0]] <= sd_in;
      end
    end

    // Pointers, credit counter and the registered output stage of child i.
    // A send and a return in the same cycle cancel and leave credit as is.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        credit  <= CRED_MAX;
        flit_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= pop[i];
        if (push[i]) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr <= rd_ptr + PW'(1);
          flit_q <= mem[rd_ptr[AW-1:0]];
        end
        if (pop[i] && !cred_ret[i]) begin
          credit <= credit - CW'(1);
        end else if (!pop[i] && cred_ret[i] && (credit != CRED_MAX)) begin
          credit <= credit + CW'(1);
        end
      end
    end

    assign out_flit[i*FLIT_W +: FLIT_W] = flit_q;
    assign out_valid[i]                 = valid_q;

  end

  // Sticky credit-overflow flag shared by all children.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_err <= 1'b0;
    end else if (|cred_ovf) begin
      cred_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cluster_hub_buf.sv
// ---------------------------------------------------------------------------
// tb_cluster_hub_buf
//
// Directed bench for cluster_hub_buf with default parameters
// (FLIT_W=20, NUM_OUT=4, FIFO_DEPTH=4, CRED_INIT=4). Inputs change 1 time
// unit after each rising edge; outputs are sampled on the falling edge.
// The broadcast section follows HUB_BCAST_EN in the same way the design does.
// ---------------------------------------------------------------------------
module tb_cluster_hub_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] sd_in;
  logic        sd_in_valid;
  logic        sd_in_ready;
  logic [3:0]  cred_ret;
  logic [79:0] out_flit;
  logic [3:0]  out_valid;
  logic [3:0]  fifo_full;
  logic        cred_err;

  int tests = 0;
  int fails = 0;

  // Delivery monitor: pulse count and last value per child, plus the order
  // of everything child 0 receives.
  int          cnt [4] = '{default: 0};
  logic [19:0] last [4];
  logic [19:0] q0 [$];
  int          base0;
  int          total;

  cluster_hub_buf dut (
    .clk         (clk),
    .rst         (rst),
    .sd_in       (sd_in),
    .sd_in_valid (sd_in_valid),
    .sd_in_ready (sd_in_ready),
    .cred_ret    (cred_ret),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .fifo_full   (fifo_full),
    .cred_err    (cred_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i]) begin
          cnt[i]  = cnt[i] + 1;
          last[i] = out_flit[i*20 +: 20];
          if (i == 0) q0.push_back(out_flit[19:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [19:0] flit, input logic valid,
                               input logic [3:0] cred);
    sd_in       = flit;
    sd_in_valid = valid;
    cred_ret    = cred;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(20'h00001, 1'b1, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready",    sd_in_ready, 0);
    checkOutput("rst_valid",    out_valid,   0);
    checkOutput("rst_flit",     out_flit,    0);
    checkOutput("rst_full",     fifo_full,   0);
    checkOutput("rst_cred_err", cred_err,    0);

    // Reset release cycle t carries the first flit (dest 1), then dest 2.
    nextCycle();
    rst = 1'b0;
    applyStimulus(20'h00001, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("t0_ready", sd_in_ready, 1);
    nextCycle();
    applyStimulus(20'h00002, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("t1_ready", sd_in_ready, 1);
    checkOutput("t1_valid", out_valid,   0);
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("t2_valid", out_valid, 4'b0010);
    checkOutput("t2_flit",  out_flit,  {20'h0, 20'h0, 20'h00001, 20'h0});
    nextCycle();
    @(negedge clk);
    checkOutput("t3_valid", out_valid, 4'b0100);
    checkOutput("t3_flit",  out_flit,  {20'h0, 20'h00002, 20'h00001, 20'h0});
    nextCycle();
    @(negedge clk);
    checkOutput("t4_valid", out_valid, 0);

    // Back-to-back flits to child 0: 4 drain on credit, 4 more fill the FIFO.
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      applyStimulus(20'(k * 16), 1'b1, 4'h0);
      @(negedge clk);
      checkOutput("fill_ready", sd_in_ready, 1);
    end
    nextCycle();
    applyStimulus(20'h00090, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("full0_ready", sd_in_ready, 0);
    checkOutput("full0_flag",  fifo_full,   4'b0001);
    #1;
    applyStimulus(20'h00033, 1'b1, 4'h0);
    #1;
    checkOutput("dest3_ready", sd_in_ready, 1);
    nextCycle();
    applyStimulus(20'h000A0, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("flit10_ready", sd_in_ready, 0);
    repeat (6) begin
      nextCycle();
      applyStimulus(20'h0, 1'b0, 4'h0);
    end
    nextCycle();
    checkOutput("stall_count0", cnt[0],     4);
    checkOutput("stall_q0_size", q0.size(), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("stall_order0", q0[k], 20'((k + 1) * 16));
    end
    checkOutput("dest3_count", cnt[3],    1);
    checkOutput("dest3_value", last[3],   20'h00033);
    checkOutput("stall_full",  fifo_full, 4'b0001);

    // One credit return on child 0 releases exactly one more flit.
    applyStimulus(20'h0, 1'b0, 4'b0001);
    @(negedge clk);
    checkOutput("ret_r0_valid", out_valid, 0);
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("ret_r1_valid", out_valid, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("ret_r2_valid", out_valid,      4'b0001);
    checkOutput("ret_r2_flit",  out_flit[19:0], 20'h00050);
    checkOutput("ret_r2_full",  fifo_full,      0);
    repeat (4) nextCycle();
    checkOutput("ret_count0", cnt[0], 5);
    checkOutput("ret_order0", q0[4],  20'h00050);

    // Child 2 back at full credit, then a send and a return every cycle.
    applyStimulus(20'h0, 1'b0, 4'b0100);
    @(negedge clk);
    checkOutput("c2_refill_err", cred_err, 0);
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      applyStimulus(20'((k + 1) * 256 + 2), (k < 8),
                    ((k >= 1) && (k <= 8)) ? 4'b0100 : 4'b0000);
      @(negedge clk);
      if (k < 8) checkOutput("stream_ready", sd_in_ready, 1);
      checkOutput("stream_valid2", out_valid[2], (k >= 2));
      if (k >= 2) checkOutput("stream_flit2", out_flit[40 +: 20], 20'((k - 1) * 256 + 2));
    end
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("stream_end_valid", out_valid[2], 0);
    checkOutput("stream_end_err",   cred_err,     0);
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'b0100);
    @(negedge clk);
    checkOutput("extra_ret_pre_err", cred_err, 0);
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("extra_ret_err", cred_err, 1);

    // Reset mid-operation with flits still queued.
    nextCycle();
    applyStimulus(20'h0A001, 1'b1, 4'h0);
    nextCycle();
    applyStimulus(20'h0A002, 1'b1, 4'h0);
    nextCycle();
    applyStimulus(20'h0A003, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("pre_rst_valid", out_valid, 4'b0010);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", out_valid,   0);
    checkOutput("mid_rst_flit",  out_flit,    0);
    checkOutput("mid_rst_full",  fifo_full,   0);
    checkOutput("mid_rst_err",   cred_err,    0);
    checkOutput("mid_rst_ready", sd_in_ready, 0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    applyStimulus(20'h0, 1'b0, 4'h0);
    total = cnt[0] + cnt[1] + cnt[2] + cnt[3];
    repeat (6) nextCycle();
    checkOutput("no_stale", cnt[0] + cnt[1] + cnt[2] + cnt[3], total);

    // Credits restored: 5 flits to child 0, exactly 4 delivered.
    base0 = cnt[0];
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(20'(32'h0C000 + k * 16), 1'b1, 4'h0);
      nextCycle();
    end
    applyStimulus(20'h0, 1'b0, 4'h0);
    repeat (6) nextCycle();
    checkOutput("cred_restored_count", cnt[0] - base0, 4);
    checkOutput("cred_restored_last",  last[0],        20'h0C040);
    checkOutput("cred_restored_full",  fifo_full,      0);

    // Fresh reset before the flag-bit flit.
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    applyStimulus(20'h80002, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("bc_ready", sd_in_ready, 1);
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("bc_t1_valid", out_valid, 0);
    nextCycle();
    @(negedge clk);
`ifdef HUB_BCAST_EN
    checkOutput("bc_valid", out_valid, 4'b1111);
    checkOutput("bc_flit",  out_flit,  {4{20'h80002}});
    for (int k = 1; k <= 7; k++) begin
      nextCycle();
      applyStimulus(20'(k * 16 + 1), 1'b1, 4'h0);
      @(negedge clk);
      checkOutput("bc_fill1_ready", sd_in_ready, 1);
    end
    nextCycle();
    applyStimulus(20'h80002, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("bc_blocked_ready", sd_in_ready, 0);
    checkOutput("bc_blocked_full",  fifo_full,   4'b0010);
    #1;
    applyStimulus(20'h00010, 1'b1, 4'h0);
    #1;
    checkOutput("bc_unicast0_ready", sd_in_ready, 1);
    nextCycle();
    applyStimulus(20'h0, 1'b0, 4'h0);
`else
    checkOutput("payload_valid", out_valid, 4'b0100);
    checkOutput("payload_flit",  out_flit,  {20'h0, 20'h80002, 20'h0, 20'h0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_hub_buf.md
# cluster_hub_buf

Parametrised, buffered successor to the cluster-hub demultiplexer. It accepts flits from the crossbar hub port with a valid/ready handshake and steers each flit by its destination field to one of `NUM_OUT` child routers. Each child has its own FIFO and credit counter, so per-child backpressure replaces the single OR-ed credit. It sits between crossbar output o4 and the child routers of a cluster.

## Interface
- `FLIT_W`, 20: flit width in bits.
- `NUM_OUT`, 4: child count; power of two, 2..16.
- `DEST_LSB`, 0: LSB of destination field; field width `DW = $clog2(NUM_OUT)`.
- `FIFO_DEPTH`, 4: per-child FIFO depth; power of two, ≥2.
- `CRED_INIT`, 4: credits per child after reset; this is the child input buffer depth.
- `BCAST_BIT`, `FLIT_W-1`: broadcast flag bit. Used only with `HUB_BCAST_EN`.

Ports:
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sd_in`, input, `FLIT_W`: incoming flit.
- `sd_in_valid`, input, 1: `sd_in` is valid.
- `sd_in_ready`, output, 1: the hub accepts the flit this cycle. Combinational from `sd_in` and FIFO state.
- `cred_ret`, input, `NUM_OUT`: one-cycle pulse per credit returned by child i (bit i).
- `out_flit`, output, `NUM_OUT*FLIT_W`: flit to child i on slice `[i*FLIT_W +: FLIT_W]`; registered.
- `out_valid`, output, `NUM_OUT`: one-cycle pulse per delivered flit; registered.
- `fifo_full`, output, `NUM_OUT`: FIFO i is full; registered state.
- `cred_err`, output, 1: sticky flag for credit overflow.

## Operation
- Destination: `dest = sd_in[DEST_LSB +: DW]`.
- Handshake: a transfer occurs when `sd_in_valid && sd_in_ready`.
  - `sd_in_ready = !fifo_full[dest]`.
  - Held at 0 while `rst` is high.
  - When `sd_in_valid` is low, `sd_in_ready` still reflects `!fifo_full[dest]` and is don't-care to the sender.
- On a transfer, the flit is pushed into FIFO[dest] unmodified.
- Full FIFO: a pop in the same cycle does not allow a push. Ready uses pre-edge full state only.
- Per child i, each cycle:
  - If FIFO i is non-empty and `credit[i] > 0`, pop the head into `out_flit[i]`, assert `out_valid[i]` for one cycle, and decrement `credit[i]`.
  - Otherwise `out_valid[i]` = 0 and `out_flit[i]` holds its last value.
- Credit counters:
  - Width is `$clog2(CRED_INIT+1)`.
  - `cred_ret[i]` increments the counter.
  - A send and a return in the same cycle leave the counter unchanged.
  - A return while the counter equals `CRED_INIT` with no send is ignored, and sets `cred_err`. `cred_err` clears only on reset.
  - The counter never wraps below 0, because a send requires credit > 0.
- Channels are independent; no cross-channel arbitration is needed.
- FIFOs use wrap-around read/write pointers with an extra MSB for full/empty detection.

## Timing
- Reset (async assert, sampled release):
  - `out_flit` = 0, `out_valid` = 0, `fifo_full` = 0, `cred_err` = 0.
  - FIFOs empty; `credit[i] = CRED_INIT`.
  - A flit offered in the reset-release cycle is accepted only if `rst` is low in that cycle.
- Latency: a transfer in cycle t with an empty FIFO and credit available gives `out_valid[dest]` high in cycle t+2.
- Throughput: 1 flit/cycle into the hub; 1 flit/cycle per child while credits last.
- With `CRED_INIT` credits and no returns, a child receives exactly `CRED_INIT` flits, then stalls.
- A return in cycle t allows a send that appears on `out_valid` in cycle t+2.
- Reset asserted mid-operation discards all buffered flits and restores credits immediately.

## Configuration
- `HUB_BCAST_EN` defined: a flit with `sd_in[BCAST_BIT]=1` is broadcast.
  - `sd_in_ready = !(|fifo_full)`.
  - On transfer, the flit is pushed into every FIFO in the same cycle.
  - The destination field is ignored for that flit.
- Not defined: `BCAST_BIT` is ordinary payload. Routing is by `dest` only, and no broadcast logic is synthesised.

## Test plan
- Reset release, defaults; send `20'h00001` then `20'h00002`:
  - `out_valid[1]` pulses in cycle t+2 with `20'h00001`.
  - `out_valid[2]` pulses in cycle t+3 with `20'h00002`.
  - Other outputs stay 0.
- 10 back-to-back flits to child 0 with no `cred_ret`:
  - Exactly 4 delivered.
  - FIFO fills after 4 more.
  - `sd_in_ready` drops when dest=0 while dest=3 flits are still accepted.
- After that stall, pulse `cred_ret[0]` once:
  - Exactly one further flit is delivered, 2 cycles later.
  - Flits arrive in order.
- Simultaneous send and `cred_ret[2]` every cycle: credit stays at 4 and child 2 sustains 1 flit/cycle. Separately, an extra `cred_ret[2]` at full credit sets `cred_err`.
- Assert `rst` with flits buffered in all FIFOs:
  - All outputs are 0 immediately.
  - After release, no stale flit appears and credits are back to 4.
- `HUB_BCAST_EN`, flit `20'h80002`:
  - All 4 `out_valid` bits pulse together with that value.
  - With FIFO 1 full, `sd_in_ready` = 0 for the broadcast flit.
